// File: rtl/exec_muldiv_if.sv
// exec_muldiv_if
//   Bundle between the EX stage (master) and the multi-cycle mul/div unit
//   (slave), including the result path toward MA/write-back.
//
//   Request handshake: a request transfers on a rising clk edge when
//   req_valid_ex, cpu_stat_ex and req_ready are all high and kill is low.
//   req_ready is high only while the unit is idle. The master holds the
//   request fields stable for that one cycle only. A request that is not
//   accepted is dropped and must be re-presented. There is no back-pressure
//   on the result side. res_valid_ma is a single-cycle strobe, and
//   rd_adr_ma/rd_data_ma are meaningful only while it is high.
//
//   Signals:
//     req_valid_ex  M-op request from EX
//     cpu_stat_ex   EX stage is executing; qualifies req_valid_ex
//     req_ready     unit idle, able to accept
//     md_code_ex    funct3 of the M-op
//     rs1_data_ex   operand A
//     rs2_data_ex   operand B
//     rd_adr_ex     destination register
//     kill          pipeline flush, aborts any operation in flight
//     md_busy       stall request toward IF/ID/EX
//     res_valid_ma  result strobe
//     rd_adr_ma     destination of the result
//     rd_data_ma    result data
interface exec_muldiv_if #(
   parameter int XLEN   = 32,
   parameter int RADR_W = 5
);
   logic              req_valid_ex;
   logic              cpu_stat_ex;
   logic              req_ready;
   logic [2:0]        md_code_ex;
   logic [XLEN-1:0]   rs1_data_ex;
   logic [XLEN-1:0]   rs2_data_ex;
   logic [RADR_W-1:0] rd_adr_ex;
   logic              kill;
   logic              md_busy;
   logic              res_valid_ma;
   logic [RADR_W-1:0] rd_adr_ma;
   logic [XLEN-1:0]   rd_data_ma;

   modport master (
      output req_valid_ex, cpu_stat_ex, md_code_ex, rs1_data_ex,
             rs2_data_ex, rd_adr_ex, kill,
      input  req_ready, md_busy, res_valid_ma, rd_adr_ma, rd_data_ma
   );

   modport slave (
      input  req_valid_ex, cpu_stat_ex, md_code_ex, rs1_data_ex,
             rs2_data_ex, rd_adr_ex, kill,
      output req_ready, md_busy, res_valid_ma, rd_adr_ma, rd_data_ma
   );
endinterface

// File: rtl/exec_muldiv.sv
// exec_muldiv
//   Multi-cycle RV32 M-extension unit in the EX stage. It runs a radix-2
//   shift-add multiply and a restoring divide, one bit per cycle, on operand
//   magnitudes. The result sign is applied when the result is registered.
//   Divide-by-zero and signed overflow finish in one cycle.
//
//   Optional feature macro: MULDIV_FAST_MUL_EN. When it is defined, all
//   multiplies use a combinational multiplier at accept and finish in one
//   cycle.
//
//   Ports:
//     clk        clock
//     rst        synchronous active-high reset
//     bus        exec_muldiv_if.slave (request, stall and result signals)
//     dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
module exec_muldiv #(
   parameter int XLEN   = 32,
   parameter int RADR_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   exec_muldiv_if.slave bus,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [2:0]        code_q;
   logic              neg_q;
   logic [RADR_W-1:0] rd_q;
   logic [XLEN-1:0]   mcand_q;   // multiplicand for mul, divisor for div
   logic [2*XLEN-1:0] prod_q;    // {acc, multiplier} or {remainder, quotient}
   logic [2*XLEN-1:0] prod_nxt;
   logic [CW-1:0]     cnt_q;

   // Decode of the incoming request
   logic [2:0]      code;
   logic            acc;
   logic            is_div;
   logic            sgn_a, sgn_b, a_neg, b_neg, neg_in;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, spec_in;
   logic [XLEN-1:0] spec_res;
   logic            fast_sel;
   logic [2*XLEN-1:0] fast_p;

   assign code   = bus.md_code_ex;
   assign acc    = bus.req_valid_ex & bus.cpu_stat_ex & bus.req_ready & ~bus.kill;
   assign is_div = code[2];

   // MULH, DIV and REM are signed on both operands; MULHSU only on rs1
   assign sgn_a = (code == 3'd1) | (code == 3'd2) | (code == 3'd4) | (code == 3'd6);
   assign sgn_b = (code == 3'd1) | (code == 3'd4) | (code == 3'd6);
   assign a_neg = sgn_a & bus.rs1_data_ex[XLEN-1];
   assign b_neg = sgn_b & bus.rs2_data_ex[XLEN-1];
   assign a_mag = a_neg ? -bus.rs1_data_ex : bus.rs1_data_ex;
   assign b_mag = b_neg ? -bus.rs2_data_ex : bus.rs2_data_ex;
   // A remainder follows the dividend's sign. Everything else is negative
   // when the operand signs differ.
   assign neg_in = (code[2] & code[1]) ? a_neg : (a_neg ^ b_neg);

   assign div_zero = is_div & (bus.rs2_data_ex == '0);
   assign div_ovf  = is_div & ~code[0]
                   & (bus.rs1_data_ex == {1'b1, {(XLEN-1){1'b0}}})
                   & (bus.rs2_data_ex == '1);
   assign spec_in  = div_zero | div_ovf;

   always_comb begin
      spec_res = '0;
      if (div_zero) spec_res = code[1] ? bus.rs1_data_ex : '1;
      else          spec_res = code[1] ? '0 : bus.rs1_data_ex;
   end

`ifdef MULDIV_FAST_MUL_EN
   assign fast_sel = ~code[2];
   assign fast_p   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
   assign fast_sel = 1'b0;
   assign fast_p   = '0;
`endif

   // Apply the sign to the magnitude result and pick the field for the op
   function automatic logic [XLEN-1:0] fix_result(input logic [2:0] c,
                                                  input logic neg,
                                                  input logic [2*XLEN-1:0] p);
      logic [2*XLEN-1:0] pn;
      logic [XLEN-1:0]   q, r, res;
      pn  = neg ? -p : p;
      q   = neg ? -p[XLEN-1:0] : p[XLEN-1:0];
      r   = neg ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
      res = '0;
      if (c[2])            res = c[1] ? r : q;
      else if (c == 3'd0)  res = pn[XLEN-1:0];
      else                 res = pn[2*XLEN-1:XLEN];
      return res;
   endfunction

   // One iteration step
   logic [XLEN:0] add_sum, rem_shift, diff;

   always_comb begin
      prod_nxt  = prod_q;
      add_sum   = '0;
      rem_shift = '0;
      diff      = '0;
      if (code_q[2]) begin
         // Shift in the next dividend bit, then trial-subtract the divisor.
         // The remainder stays below the divisor, so diff[XLEN] is a borrow.
         rem_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
         diff      = rem_shift - {1'b0, mcand_q};
         if (!diff[XLEN])
            prod_nxt = {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
         else
            prod_nxt = {rem_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
      end else begin
         add_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]}
                  + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
         prod_nxt = {add_sum, prod_q[XLEN-1:1]};
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (acc) state_nxt = (spec_in | fast_sel) ? DONE : CALC;
         CALC: begin
            if (bus.kill)                state_nxt = IDLE;
            else if (cnt_q == CW'(1))    state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.req_ready    = (state == IDLE);
   assign bus.md_busy      = (state != IDLE);
   assign bus.res_valid_ma = (state == DONE) & ~bus.kill;
   assign dbg_state        = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         code_q         <= '0;
         neg_q          <= 1'b0;
         rd_q           <= '0;
         mcand_q        <= '0;
         prod_q         <= '0;
         cnt_q          <= '0;
         bus.rd_adr_ma  <= '0;
         bus.rd_data_ma <= '0;
      end else begin
         state <= state_nxt;
         if (acc) begin
            code_q  <= code;
            neg_q   <= neg_in;
            rd_q    <= bus.rd_adr_ex;
            mcand_q <= is_div ? b_mag : a_mag;
            prod_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt_q   <= CW'(XLEN);
            if (spec_in | fast_sel) begin
               bus.rd_adr_ma  <= bus.rd_adr_ex;
               bus.rd_data_ma <= fast_sel ? fix_result(code, neg_in, fast_p) : spec_res;
            end
         end else if (state == CALC) begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q - CW'(1);
            // Register the final result on the last iteration so it is valid in DONE
            if ((cnt_q == CW'(1)) && !bus.kill) begin
               bus.rd_adr_ma  <= rd_q;
               bus.rd_data_ma <= fix_result(code_q, neg_q, prod_nxt);
            end
         end
      end
   end

endmodule

// File: doc/exec_muldiv.md
# exec_muldiv

Parametrised multi-cycle multiply/divide execution unit for the RV32 pipeline, alongside the single-cycle ALU in the EX stage. It accepts M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) from EX and holds the pipeline with a busy signal while it iterates. It returns one result with its destination register toward the MA/write-back path, and it can be killed by a jump or exception flush.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be ≥8 and a power of two
- RADR_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid_ex  in  1  M-op request, qualified by cpu_stat_ex
- cpu_stat_ex  in  1  EX stage executing; request ignored when low
- req_ready  out  1  high only in IDLE
- md_code_ex  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data_ex  in  XLEN  operand A
- rs2_data_ex  in  XLEN  operand B
- rd_adr_ex  in  RADR_W  destination register
- kill  in  1  flush: abort the current operation
- md_busy  out  1  stall request to IF/ID/EX; high when state ≠ IDLE
- res_valid_ma  out  1  one-cycle result strobe
- rd_adr_ma  out  RADR_W  destination of the result
- rd_data_ma  out  XLEN  result data

## Operation
- States: IDLE, CALC, DONE.
- Accept: `acc = req_valid_ex & cpu_stat_ex & req_ready & ~kill`. On accept, latch the code, rd_adr and operands, then move to CALC. Special divide cases go straight to DONE.
- Signed ops (MULH, DIV, REM; rs1 only for MULHSU) convert operands to magnitude at accept. The result sign is fixed in DONE.
- Multiply: radix-2 shift-add with a 2·XLEN product register, XLEN iterations.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, XLEN iterations.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved at accept with 1-cycle latency:
  - Divide by zero: quotient all ones; remainder = rs1.
  - Signed overflow (rs1 = 2^(XLEN-1), rs2 = −1): quotient = rs1; remainder = 0.
- Counter: width log2(XLEN)+1. Loaded with XLEN at accept, decremented in CALC. CALC→DONE when it reaches 1, after the final iteration.
- DONE: drive res_valid_ma=1 with rd_adr_ma/rd_data_ma valid, then return to IDLE.
- kill in CALC or DONE:
  - Next state is IDLE.
  - res_valid_ma is forced to 0 in that cycle, and no result is ever issued.
- kill in IDLE with req_valid_ex: the request is dropped.
- md_code_ex is taken directly from funct3 and is meaningful only when req_valid_ex=1.

## Timing
- Reset, and outputs in IDLE: state IDLE; req_ready=1; md_busy=0; res_valid_ma=0; rd_adr_ma=0; rd_data_ma=0.
- Accept at cycle 0. CALC covers cycles 1..XLEN. DONE and res_valid_ma are at cycle XLEN+1. IDLE and req_ready=1 return at cycle XLEN+2.
- Special-case divide: DONE at cycle 1; IDLE at cycle 2.
- md_busy is asserted from cycle 1 through the DONE cycle. The stall is registered and not combinational from req_valid_ex. The EX stage must hold the issuing instruction for the accept cycle only.
- rd_adr_ma/rd_data_ma are registered. They hold their last value outside DONE, and consumers qualify them with res_valid_ma.
- Back-to-back throughput: XLEN+2 cycles per operation. A request during busy is not accepted and must be re-presented.
- rst wins over kill and over acc in the same cycle.

## Configuration
- MULDIV_FAST_MUL_EN:
  - Defined: MUL, MULH, MULHSU and MULHU use a single-cycle XLEN×XLEN combinational multiplier evaluated at accept, with the result registered into DONE. Latency is 1 cycle (res_valid_ma at cycle 1). Divide is unchanged.
  - Undefined: all multiplies iterate and complete at cycle XLEN+1 as above.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), XLEN=32 → res_valid_ma at cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN), rd_data_ma=0xFFFFFFEB, rd_adr_ma as issued.
- MULH, MULHSU and MULHU with 0x80000000 × 0x80000000 → MULH 0x40000000, MULHSU 0xC0000000, MULHU 0x40000000.
- Signed divide and remainder, and unsigned divide:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - All complete at cycle 33.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF at cycle 1.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Both at cycle 1.
- kill at cycle 10 of a DIV → IDLE at cycle 11, no res_valid_ma. A new MUL accepted at cycle 11 completes normally with its own rd_adr.
- rst asserted mid-CALC → next cycle all outputs at reset values, req_ready=1. Also check that req_valid_ex during md_busy is ignored and that a request with cpu_stat_ex=0 is ignored.
